// File: rtl/conv_acc_pkg.sv
// Shared types and constants for the conv accumulator / requantizer.
// Optional feature macro: CONV_ACC_RELU_EN (see requant_sat).
package conv_acc_pkg;

    localparam int unsigned ACT_W  = 13;
    localparam int unsigned PSUM_W = 22;

    localparam int ACT_MAX = 4095;
    localparam int ACT_MIN = -4096;

    typedef enum logic [0:0] {
        StAcc,
        StHold
    } state_e;

    // Accumulator width: partial sum + tap growth + one bit for the bias term.
    function automatic int unsigned acc_width(input int unsigned num_taps);
        return PSUM_W + $clog2(num_taps) + 1;
    endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational round-half-up right shift and saturation to the activation format.
// Optional feature macro: CONV_ACC_RELU_EN clamps negative results to zero.
module requant_sat
    import conv_acc_pkg::*;
#(
    parameter int unsigned ACC_W = 25,
    parameter int unsigned SHIFT = 7
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [ACT_W-1:0] data_o,
    output logic                    sat_o
);

    // One spare bit so adding the rounding constant can never wrap.
    localparam int unsigned RW = ACC_W + 1;

    localparam logic signed [RW-1:0] RoundC = RW'(2 ** (SHIFT - 1));
    localparam logic signed [RW-1:0] RMax   = RW'(ACT_MAX);
    localparam logic signed [RW-1:0] RMin   = RW'(ACT_MIN);

    logic signed [RW-1:0] rnd_sum;
    logic signed [RW-1:0] r;

    assign rnd_sum = RW'(acc_i) + RoundC;
    assign r       = rnd_sum >>> SHIFT;

    // Clamp to the activation range and flag any clamping.
    always_comb begin
        data_o = r[ACT_W-1:0];
        sat_o  = 1'b0;
`ifdef CONV_ACC_RELU_EN
        if (r < 0) begin
            data_o = '0;
        end else if (r > RMax) begin
            data_o = ACT_W'(ACT_MAX);
            sat_o  = 1'b1;
        end
`else
        if (r > RMax) begin
            data_o = ACT_W'(ACT_MAX);
            sat_o  = 1'b1;
        end else if (r < RMin) begin
            data_o = ACT_W'(ACT_MIN);
            sat_o  = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/conv_acc_requant.sv
// Accumulates NUM_TAPS MAC partial sums plus a bias, then requantizes to 13 bits.
// Drives the MAC weight-set select (tap_idx_o) so both stay in lock-step.
// Optional feature macro: CONV_ACC_RELU_EN (ReLU in requant_sat).
module conv_acc_requant
    import conv_acc_pkg::*;
#(
    parameter int unsigned NUM_TAPS = 4,
    parameter int unsigned SHIFT    = 7
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic signed [PSUM_W-1:0]      in_sum_i,
    input  logic signed [PSUM_W-1:0]      bias_i,
    output logic [$clog2(NUM_TAPS)-1:0]   tap_idx_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic signed [ACT_W-1:0]       out_data_o,
    output logic                          out_sat_o,
    output logic                          busy_o
);

    localparam int unsigned ACC_W = acc_width(NUM_TAPS);
    localparam int unsigned TapW  = $clog2(NUM_TAPS);
    localparam logic [TapW-1:0] TapLast = TapW'(NUM_TAPS - 1);

    state_e                   state_q, state_d;
    logic [TapW-1:0]          tap_q, tap_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACT_W-1:0]  data_q, data_d;
    logic                     sat_q, sat_d;

    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [ACT_W-1:0]  rq_data;
    logic                     rq_sat;

    // First tap of a group starts from the bias instead of the old sum.
    assign acc_sum = ((tap_q == '0) ? ACC_W'(bias_i) : acc_q) + ACC_W'(in_sum_i);

    requant_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_requant_sat (
        .acc_i  (acc_sum),
        .data_o (rq_data),
        .sat_o  (rq_sat)
    );

    // Next-state: accept taps in StAcc, hold the result in StHold until taken.
    always_comb begin
        state_d = state_q;
        tap_d   = tap_q;
        acc_d   = acc_q;
        data_d  = data_q;
        sat_d   = sat_q;
        unique case (state_q)
            StAcc: begin
                if (in_valid_i) begin
                    acc_d = acc_sum;
                    if (tap_q == TapLast) begin
                        tap_d   = '0;
                        data_d  = rq_data;
                        sat_d   = rq_sat;
                        state_d = StHold;
                    end else begin
                        tap_d = tap_q + TapW'(1);
                    end
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    state_d = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    // State, tap counter, accumulator and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StAcc;
            tap_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tap_q   <= tap_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
        end
    end

    assign in_ready_o  = (state_q == StAcc);
    assign out_valid_o = (state_q == StHold);
    assign tap_idx_o   = tap_q;
    assign out_data_o  = data_q;
    assign out_sat_o   = sat_q;
    assign busy_o      = (tap_q != '0) || (state_q == StHold);

endmodule

// File: tb/tb_conv_acc_requant.sv
// Directed, table-driven bench for conv_acc_requant (default NUM_TAPS=4, SHIFT=7).
module tb_conv_acc_requant;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [21:0] in_sum = '0;
    logic signed [21:0] bias = '0;
    logic [1:0]         tap_idx;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [12:0] out_data;
    logic               out_sat;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    conv_acc_requant #(
        .NUM_TAPS (4),
        .SHIFT    (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_sum_i    (in_sum),
        .bias_i      (bias),
        .tap_idx_o   (tap_idx),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_sat_o   (out_sat),
        .busy_o      (busy)
    );

    typedef struct {
        string              name;
        logic signed [21:0] b;
        logic [3:0][21:0]   taps;
        int                 exp_data;  // signed-output expectation
        logic               exp_sat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Map a signed-output expectation to the configured output mode.
    function automatic int exp_d(input int d);
`ifdef CONV_ACC_RELU_EN
        return (d < 0) ? 0 : d;
`else
        return d;
`endif
    endfunction

    function automatic int exp_s(input int d, input logic s);
`ifdef CONV_ACC_RELU_EN
        return (d < 0) ? 0 : int'(s);
`else
        return int'(s);
`endif
    endfunction

    // Present one tap at a negedge and let the next posedge accept it.
    task automatic drive_tap(input string nm, input int k, input logic signed [21:0] b,
                             input logic signed [21:0] s);
        in_valid = 1'b1;
        in_sum   = s;
        bias     = b;
        chk($sformatf("%s tap_idx before tap %0d", nm, k), int'(tap_idx), k);
        chk($sformatf("%s in_ready tap %0d", nm, k), int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge right after the last tap's accept edge.
    task automatic check_out(input string nm, input int d, input logic s);
        chk({nm, " out_valid"}, int'(out_valid), 1);
        chk({nm, " out_data"}, int'(out_data), exp_d(d));
        chk({nm, " out_sat"}, int'(out_sat), exp_s(d, s));
        chk({nm, " tap_idx wrap"}, int'(tap_idx), 0);
        chk({nm, " in_ready hold"}, int'(in_ready), 0);
        chk({nm, " busy hold"}, int'(busy), 1);
        @(posedge clk);
        @(negedge clk);
        chk({nm, " out_valid drop"}, int'(out_valid), 0);
        chk({nm, " busy idle"}, int'(busy), 0);
    endtask

    initial begin
        // name, bias, taps (tap3..tap0 packed), expected data, expected sat
        vecs[0]  = '{"basic", 22'sd0, {22'sd400, 22'sd300, 22'sd200, 22'sd100}, 8, 1'b0};
        vecs[1]  = '{"neg_bias", -22'sd1000, {22'sd0, 22'sd0, 22'sd0, 22'sd0}, -8, 1'b0};
        vecs[2]  = '{"sat_pos", 22'sd0,
                     {22'sd2097151, 22'sd2097151, 22'sd2097151, 22'sd2097151}, 4095, 1'b1};
        vecs[3]  = '{"sat_neg", 22'sd0,
                     {-22'sd2097152, -22'sd2097152, -22'sd2097152, -22'sd2097152}, -4096, 1'b1};
        vecs[4]  = '{"rnd_up", 22'sd64, {22'sd0, 22'sd0, 22'sd0, 22'sd0}, 1, 1'b0};
        vecs[5]  = '{"rnd_dn", 22'sd63, {22'sd0, 22'sd0, 22'sd0, 22'sd0}, 0, 1'b0};
        vecs[6]  = '{"rnd_neg_half", -22'sd64, {22'sd0, 22'sd0, 22'sd0, 22'sd0}, 0, 1'b0};
        vecs[7]  = '{"rnd_neg", -22'sd65, {22'sd0, 22'sd0, 22'sd0, 22'sd0}, -1, 1'b0};
        vecs[8]  = '{"max_edge", 22'sd524160, {22'sd0, 22'sd0, 22'sd0, 22'sd0}, 4095, 1'b0};
        vecs[9]  = '{"max_over", 22'sd524224, {22'sd0, 22'sd0, 22'sd0, 22'sd0}, 4095, 1'b1};
        vecs[10] = '{"min_edge", -22'sd524288, {22'sd0, 22'sd0, 22'sd0, 22'sd0}, -4096, 1'b0};
        vecs[11] = '{"mixed", 22'sd1000, {22'sd5000, -22'sd75, 22'sd25, -22'sd50}, 46, 1'b0};

        // Reset state.
        @(negedge clk);
        chk("reset tap_idx", int'(tap_idx), 0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset out_data", int'(out_data), 0);
        chk("reset out_sat", int'(out_sat), 0);
        chk("reset in_ready", int'(in_ready), 1);
        chk("reset busy", int'(busy), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven groups, back-to-back taps.
        for (int v = 0; v < 12; v++) begin
            for (int k = 0; k < 4; k++) begin
                drive_tap(vecs[v].name, k, vecs[v].b, $signed(vecs[v].taps[k]));
                if (k < 3) chk({vecs[v].name, " busy mid"}, int'(busy), 1);
            end
            check_out(vecs[v].name, vecs[v].exp_data, vecs[v].exp_sat);
        end

        // Below -4096 only clamps when output is signed.
        drive_tap("min_over", 0, -22'sd524353, 22'sd0);
        for (int k = 1; k < 4; k++) drive_tap("min_over", k, -22'sd524353, 22'sd0);
        check_out("min_over", -4097 < -4096 ? -4096 : 0, 1'b1);

        // Backpressure: out_ready low 3 cycles with in_valid high.
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) drive_tap("bp", k, 22'sd0, 22'(100 * (k + 1)));
        in_valid = 1'b1;
        in_sum   = 22'sd7000;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("bp out_valid c%0d", c), int'(out_valid), 1);
            chk($sformatf("bp out_data c%0d", c), int'(out_data), 8);
            chk($sformatf("bp in_ready c%0d", c), int'(in_ready), 0);
            chk($sformatf("bp tap_idx c%0d", c), int'(tap_idx), 0);
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp released out_valid", int'(out_valid), 0);
        chk("bp no tap consumed", int'(tap_idx), 0);
        chk("bp in_ready back", int'(in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        chk("bp first tap accepted", int'(tap_idx), 1);
        in_valid = 1'b0;
        for (int k = 1; k < 4; k++) drive_tap("bp2", k, 22'sd0, 22'sd0);
        // 7000 + 64 = 7064 >> 7 = 55
        check_out("bp2", 55, 1'b0);

        // Gapped in_valid: 1,0,0,1,1,0,1.
        begin
            logic [6:0] pat;
            int k;
            pat = 7'b1011001;  // bit i = cycle i
            k = 0;
            for (int c = 0; c < 7; c++) begin
                if (pat[c]) begin
                    drive_tap("gap", k, 22'sd0, 22'(100 * (k + 1)));
                    k++;
                end else begin
                    chk($sformatf("gap hold tap_idx c%0d", c), int'(tap_idx), k);
                    in_valid = 1'b0;
                    in_sum   = 22'sd1234;
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            check_out("gap", 8, 1'b0);
        end

        // Reset mid-group discards the partial sum.
        drive_tap("rst", 0, 22'sd100000, 22'sd100000);
        drive_tap("rst", 1, 22'sd0, 22'sd100000);
        rst_n = 1'b0;
        #1;
        chk("rst tap_idx", int'(tap_idx), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) drive_tap("post_rst", k, 22'sd0, 22'(100 * (k + 1)));
        check_out("post_rst", 8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule
